digit_scan_driver: RTL and testbench



---
 rtl/digit_scan_driver.sv | 107 ++++++++++
 tb/tb_digit_scan_driver.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_driver.sv
// Time-multiplexed digit select with prescaler, scan index, masking and strobes.
// Optional start-of-slot blanking is enabled by defining DIGIT_BLANK_EN.
module digit_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int IDX_W        = $clog2(NUM_DIGITS),
    parameter int PRESCALE     = 100000,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  slot_tick,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd2;
`ifdef DIGIT_BLANK_EN
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
`endif

    if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || PRESCALE < 2 ||
        BLANK_CYCLES >= PRESCALE || IDX_W != $clog2(NUM_DIGITS)) begin : g_bad_param
        $error("digit_scan_driver: illegal parameter set");
    end

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;
    logic                  frame_q, frame_d;
    logic [NUM_DIGITS-1:0] sel;
    logic                  active_d;

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        active_d = !reset && en;
        if (reset) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (!en) begin
            cnt_d = cnt_q;
        end else if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        state_d = S_IDLE;
        if (active_d) begin
`ifdef DIGIT_BLANK_EN
            state_d = (cnt_d < BLANK_END) ? S_BLANK : S_DRIVE;
`else
            state_d = S_DRIVE;
`endif
        end

        // strobes track the upcoming slot position so they line up with digit_idx
        tick_d  = (state_d != S_IDLE) && (cnt_d == CNT_LAST);
        frame_d = tick_d && (idx_d == IDX_LAST);

        sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel[i] = digit_mask[i] && (idx_q == IDX_W'(i));
        end
        an_d = (active_d && state_q == S_DRIVE) ? (sel ^ AN_OFF) : AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= AN_OFF;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign slot_tick  = tick_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver: three configurations against an arithmetic scan model.
module tb_digit_scan_driver;

`ifdef DIGIT_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic [7:0] mask = 8'hFF;

    logic [3:0] an0, an2;
    logic [5:0] an1;
    logic [1:0] idx0, idx2;
    logic [2:0] idx1;
    logic t0, t1, t2, f0, f1, f2;

    always #5 clk = ~clk;

    digit_scan_driver #(.NUM_DIGITS(4), .PRESCALE(3), .ACTIVE_LOW(1'b1), .BLANK_CYCLES(1)) u_d0 (
        .clk(clk), .reset(reset), .en(en), .digit_mask(mask[3:0]),
        .an(an0), .digit_idx(idx0), .slot_tick(t0), .frame_done(f0));

    digit_scan_driver #(.NUM_DIGITS(6), .PRESCALE(2), .ACTIVE_LOW(1'b1), .BLANK_CYCLES(1)) u_d1 (
        .clk(clk), .reset(reset), .en(en), .digit_mask(mask[5:0]),
        .an(an1), .digit_idx(idx1), .slot_tick(t1), .frame_done(f1));

    digit_scan_driver #(.NUM_DIGITS(4), .PRESCALE(6), .ACTIVE_LOW(1'b0), .BLANK_CYCLES(2)) u_d2 (
        .clk(clk), .reset(reset), .en(en), .digit_mask(mask[3:0]),
        .an(an2), .digit_idx(idx2), .slot_tick(t2), .frame_done(f2));

    logic [7:0] an_o[3];
    logic [7:0] idx_o[3];
    logic       tk_o[3];
    logic       fd_o[3];

    assign an_o[0] = {4'b0, an0};
    assign an_o[1] = {2'b0, an1};
    assign an_o[2] = {4'b0, an2};
    assign idx_o[0] = {6'b0, idx0};
    assign idx_o[1] = {5'b0, idx1};
    assign idx_o[2] = {6'b0, idx2};
    assign tk_o[0] = t0;
    assign tk_o[1] = t1;
    assign tk_o[2] = t2;
    assign fd_o[0] = f0;
    assign fd_o[1] = f1;
    assign fd_o[2] = f2;

    int ND[3];
    int PS[3];
    int AL[3];
    int BK[3];

    // Model: while running, n counts cycles since the run started at index base.
    bit         m_run[3];
    int         m_idx[3];
    int         m_base[3];
    int         m_n[3];
    logic [7:0] e_an[3];
    logic       e_tk[3];
    logic       e_fd[3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    function automatic int bk(int k);
        return BLANK_ON ? BK[k] : 0;
    endfunction

    function automatic logic [7:0] dec(int k, int idx, logic [7:0] m);
        logic [7:0] v;
        logic [7:0] full;
        v = '0;
        full = 8'((1 << ND[k]) - 1);
        if (m[idx]) v[idx] = 1'b1;
        return (AL[k] != 0) ? (full & ~v) : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            bit pd;
            int pi;
            pd = m_run[k] && ((m_n[k] % PS[k]) >= bk(k));
            pi = m_idx[k];
            e_an[k] = dec(k, 0, 8'h00);
            e_tk[k] = 1'b0;
            e_fd[k] = 1'b0;
            if (reset) begin
                m_run[k] = 1'b0;
                m_idx[k] = 0;
            end else if (!en) begin
                m_run[k] = 1'b0;
            end else if (!m_run[k]) begin
                m_run[k] = 1'b1;
                m_base[k] = m_idx[k];
                m_n[k] = 0;
            end else begin
                if (pd) e_an[k] = dec(k, pi, mask);
                m_n[k]++;
                m_idx[k] = (m_base[k] + m_n[k] / PS[k]) % ND[k];
            end
            if (m_run[k]) begin
                e_tk[k] = ((m_n[k] % PS[k]) == PS[k] - 1);
                e_fd[k] = e_tk[k] && (m_idx[k] == ND[k] - 1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b1;
        mask = 8'hFF;
        repeat (2) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (an_o[k] !== e_an[k] || idx_o[k] !== 8'(m_idx[k]) ||
                    tk_o[k] !== e_tk[k] || fd_o[k] !== e_fd[k]) begin
                    errors++;
                    $display("FAIL reset dut%0d cyc %0d an=%b want %b idx=%0d want %0d tick=%b want %b frame=%b want %b",
                             k, cyc, an_o[k], e_an[k], idx_o[k], m_idx[k], tk_o[k], e_tk[k], fd_o[k], e_fd[k]);
                end
            end
            checks++;
            if (an0 !== 4'b1111 || an2 !== 4'b0000 || idx0 !== 2'd0 || t0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_state an0=%b an2=%b idx0=%0d tick0=%b want 1111 0000 0 0",
                         an0, an2, idx0, t0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        int ticks[3];
        int fds[3];
        logic [3:0] w0, w2;
        for (int k = 0; k < 3; k++) begin
            ticks[k] = 0;
            fds[k] = 0;
        end
        for (int j = 1; j <= 24; j++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (an_o[k] !== e_an[k] || idx_o[k] !== 8'(m_idx[k]) ||
                    tk_o[k] !== e_tk[k] || fd_o[k] !== e_fd[k]) begin
                    errors++;
                    $display("FAIL scan dut%0d cyc %0d an=%b want %b idx=%0d want %0d tick=%b want %b frame=%b want %b",
                             k, cyc, an_o[k], e_an[k], idx_o[k], m_idx[k], tk_o[k], e_tk[k], fd_o[k], e_fd[k]);
                end
                ticks[k] += int'(tk_o[k]);
                fds[k] += int'(fd_o[k]);
            end
            w0 = 4'b1111;
            w2 = 4'b0000;
            if (j >= 2) begin
                if ((j - 2) % 3 >= bk(0)) w0 = 4'b1111 ^ (4'b0001 << (((j - 2) / 3) % 4));
                if ((j - 2) % 6 >= bk(2)) w2 = 4'b0001 << (((j - 2) / 6) % 4);
            end
            checks++;
            if (an0 !== w0 || an2 !== w2) begin
                errors++;
                $display("FAIL scan_pattern step %0d an0=%b want %b an2=%b want %b", j, an0, w0, an2, w2);
            end
        end
        checks++;
        if (ticks[0] != 8 || fds[0] != 2 || ticks[1] != 12 || fds[1] != 2 || ticks[2] != 4 || fds[2] != 1) begin
            errors++;
            $display("FAIL strobe_counts got %0d/%0d %0d/%0d %0d/%0d want 8/2 12/2 4/1",
                     ticks[0], fds[0], ticks[1], fds[1], ticks[2], fds[2]);
        end
    endtask

    task automatic test_idx_range();
        int last_fd = -1;
        for (int j = 0; j < 40; j++) begin
            step();
            checks++;
            if (idx1 >= 3'd6) begin
                errors++;
                $display("FAIL idx_range cyc %0d idx1=%0d want <6", cyc, idx1);
            end
            if (f1 === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (cyc - last_fd != 12) begin
                        errors++;
                        $display("FAIL frame_period got %0d want 12", cyc - last_fd);
                    end
                end
                last_fd = cyc;
            end
        end
    endtask

    task automatic test_mask();
        mask = 8'b0000_1010;
        for (int j = 0; j < 24; j++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (an_o[k] !== e_an[k] || idx_o[k] !== 8'(m_idx[k]) ||
                    tk_o[k] !== e_tk[k] || fd_o[k] !== e_fd[k]) begin
                    errors++;
                    $display("FAIL mask dut%0d cyc %0d an=%b want %b idx=%0d want %0d tick=%b want %b frame=%b want %b",
                             k, cyc, an_o[k], e_an[k], idx_o[k], m_idx[k], tk_o[k], e_tk[k], fd_o[k], e_fd[k]);
                end
            end
            checks++;
            if (an0 !== 4'b1111 && an0 !== 4'b1101 && an0 !== 4'b0111) begin
                errors++;
                $display("FAIL mask_lit cyc %0d an0=%b want 1111/1101/0111", cyc, an0);
            end
        end
        mask = 8'hFF;
    endtask

    task automatic test_pause();
        int seen2 = 0;
        for (int i = 0; i < 60 && !(m_idx[0] == 2 && m_n[0] % 3 == 1); i++) step();
        checks++;
        if (!(m_idx[0] == 2 && m_n[0] % 3 == 1)) begin
            errors++;
            $display("FAIL pause_wait idx=%0d want 2 mid-slot within 60 cycles", m_idx[0]);
        end
        en = 1'b0;
        repeat (5) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (an_o[k] !== e_an[k] || idx_o[k] !== 8'(m_idx[k]) ||
                    tk_o[k] !== e_tk[k] || fd_o[k] !== e_fd[k]) begin
                    errors++;
                    $display("FAIL pause dut%0d cyc %0d an=%b want %b idx=%0d want %0d tick=%b want %b frame=%b want %b",
                             k, cyc, an_o[k], e_an[k], idx_o[k], m_idx[k], tk_o[k], e_tk[k], fd_o[k], e_fd[k]);
                end
            end
            checks++;
            if (idx0 !== 2'd2 || an0 !== 4'b1111 || t0 !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold idx0=%0d an0=%b tick0=%b want 2 1111 0", idx0, an0, t0);
            end
        end
        en = 1'b1;
        repeat (6) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (an_o[k] !== e_an[k] || idx_o[k] !== 8'(m_idx[k]) ||
                    tk_o[k] !== e_tk[k] || fd_o[k] !== e_fd[k]) begin
                    errors++;
                    $display("FAIL resume dut%0d cyc %0d an=%b want %b idx=%0d want %0d tick=%b want %b frame=%b want %b",
                             k, cyc, an_o[k], e_an[k], idx_o[k], m_idx[k], tk_o[k], e_tk[k], fd_o[k], e_fd[k]);
                end
            end
            if (idx0 === 2'd2) seen2++;
        end
        checks++;
        if (seen2 != 3) begin
            errors++;
            $display("FAIL resume_slot idx2 cycles got %0d want 3", seen2);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 60 && !(m_idx[0] == 3 && m_n[0] % 3 == 1); i++) step();
        checks++;
        if (!(m_idx[0] == 3 && m_n[0] % 3 == 1)) begin
            errors++;
            $display("FAIL reset_mid_wait idx=%0d want 3 mid-slot within 60 cycles", m_idx[0]);
        end
        reset = 1'b1;
        step();
        checks++;
        if (an0 !== 4'b1111 || idx0 !== 2'd0 || t0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid an0=%b idx0=%0d tick0=%b want 1111 0 0", an0, idx0, t0);
        end
        reset = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (an_o[k] !== e_an[k] || idx_o[k] !== 8'(m_idx[k]) ||
                    tk_o[k] !== e_tk[k] || fd_o[k] !== e_fd[k]) begin
                    errors++;
                    $display("FAIL restart dut%0d cyc %0d an=%b want %b idx=%0d want %0d tick=%b want %b frame=%b want %b",
                             k, cyc, an_o[k], e_an[k], idx_o[k], m_idx[k], tk_o[k], e_tk[k], fd_o[k], e_fd[k]);
                end
            end
            if (j == 3) begin
                checks++;
                if (an0 !== 4'b1110) begin
                    errors++;
                    $display("FAIL restart_digit0 an0=%b want 1110", an0);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            en = ($urandom % 10) != 0;
            reset = ($urandom % 50) == 0;
            if ($urandom % 8 == 0) mask = 8'($urandom);
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (an_o[k] !== e_an[k] || idx_o[k] !== 8'(m_idx[k]) ||
                    tk_o[k] !== e_tk[k] || fd_o[k] !== e_fd[k]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d an=%b want %b idx=%0d want %0d tick=%b want %b frame=%b want %b",
                             k, cyc, an_o[k], e_an[k], idx_o[k], m_idx[k], tk_o[k], e_tk[k], fd_o[k], e_fd[k]);
                end
            end
        end
        reset = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        ND = '{4, 6, 4};
        PS = '{3, 2, 6};
        AL = '{1, 1, 0};
        BK = '{1, 1, 2};
        for (int k = 0; k < 3; k++) begin
            m_run[k] = 1'b0;
            m_idx[k] = 0;
            m_base[k] = 0;
            m_n[k] = 0;
        end
        test_reset();
        test_scan();
        test_idx_range();
        test_mask();
        test_pause();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
